// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Turns the EX/MEM control bundle into a req/ack transaction on the data memory. It stalls
// the pipeline until the memory acknowledges, and aborts an access after ACK_TIMEOUT request
// cycles without an ack. It also registers the MEM/WB write-back bundle.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   MEM_*                           EX/MEM bundle (control, addresses, data)
//   dmem_req/we/addr/wdata          memory request side
//   dmem_ack/rdata                  memory response (rdata valid with ack)
//   mem_stall                       freezes PC, IF/ID, ID/EX, EX/MEM
//   mem_err                         one-cycle pulse in the abort cycle
//   WB_regwrite/wraddr/wdata        registered write-back bundle
module mem_access_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_memread,
  input  logic        MEM_memwrite,
  input  logic        MEM_memtoreg,
  input  logic        MEM_regwrite,
  input  logic        MEM_link,
  input  logic [8:0]  MEM_wraddr,
  input  logic [8:0]  MEM_pc_4,
  input  logic [8:0]  MEM_address,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [8:0]  dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_err,
  output logic        WB_regwrite,
  output logic [8:0]  WB_wraddr,
  output logic [31:0] WB_wdata
);

  localparam logic [7:0] TimeoutCnt = 8'(ACK_TIMEOUT);

  typedef enum logic {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        access;
  logic        abort;
  logic [31:0] rd;
  logic [31:0] wdata_sel;

  assign access     = MEM_memread | MEM_memwrite;
  // A simultaneous read+write is treated as a write.
  assign dmem_we    = MEM_memwrite;
  assign dmem_addr  = MEM_address;
  assign dmem_wdata = MEM_store_data;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dmem_req = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      StIdle: begin
        dmem_req = access;
        if (access && !dmem_ack) begin
          state_d = StWait;
          cnt_d   = 8'd1;
        end
      end
      StWait: begin
        // Ack takes priority over the timeout in the final cycle.
        if (dmem_ack) begin
          dmem_req = 1'b1;
          state_d  = StIdle;
          cnt_d    = 8'd0;
        end else if (cnt_q == TimeoutCnt) begin
          abort   = 1'b1;
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          dmem_req = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign mem_stall = dmem_req & ~dmem_ack;
  assign mem_err   = abort;

  // An aborted load returns zero so the destination gets a defined value.
  assign rd        = abort ? 32'h0 : dmem_rdata;
  assign wdata_sel = MEM_link ? {23'b0, MEM_pc_4} : (MEM_memtoreg ? rd : MEM_alu_result);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_regwrite <= 1'b0;
      WB_wraddr   <= 9'd0;
      WB_wdata    <= 32'd0;
    end else if (mem_stall) begin
      // Bubble into WB while the access is outstanding.
      WB_regwrite <= 1'b0;
    end else begin
      WB_regwrite <= MEM_regwrite;
      WB_wraddr   <= MEM_wraddr;
      WB_wdata    <= wdata_sel;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed plus random instruction stream, checked by a
// scoreboard fed from a transaction-level model (stall length, abort, write-back value).
module tb_mem_access_ctrl;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MEM_memread = 0, MEM_memwrite = 0, MEM_memtoreg = 0, MEM_regwrite = 0;
  logic        MEM_link = 0;
  logic [8:0]  MEM_wraddr = 0, MEM_pc_4 = 0, MEM_address = 0;
  logic [31:0] MEM_alu_result = 0, MEM_store_data = 0;
  logic        dmem_req, dmem_we, dmem_ack = 0;
  logic [8:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata = 0;
  logic        mem_stall, mem_err, WB_regwrite;
  logic [8:0]  WB_wraddr;
  logic [31:0] WB_wdata;

  mem_access_ctrl #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite), .MEM_memtoreg(MEM_memtoreg),
    .MEM_regwrite(MEM_regwrite), .MEM_link(MEM_link), .MEM_wraddr(MEM_wraddr),
    .MEM_pc_4(MEM_pc_4), .MEM_address(MEM_address), .MEM_alu_result(MEM_alu_result),
    .MEM_store_data(MEM_store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_err(mem_err),
    .WB_regwrite(WB_regwrite), .WB_wraddr(WB_wraddr), .WB_wdata(WB_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        access;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] sdata;
    int          stalls;
    logic        err;
    logic        rw;
    logic [8:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: ack arriving at request-cycle index lat (0 = first cycle) completes the access if
  // lat <= T (the final counted cycle still accepts an ack); otherwise the access aborts after
  // T stall cycles and the load data is replaced by zero.
  task automatic issue(input logic rd_i, input logic wr_i, input logic m2r, input logic rw,
                       input logic lnk, input logic [8:0] wa, input logic [8:0] pc4,
                       input logic [8:0] addr, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [31:0] rdat, input int lat);
    exp_t e;
    int   cycles;
    logic [31:0] rdv;
    e.access = rd_i | wr_i;
    e.we     = wr_i;
    e.addr   = addr;
    e.sdata  = sd;
    e.err    = e.access && (lat > int'(T));
    e.stalls = !e.access ? 0 : (e.err ? int'(T) : lat);
    e.rw     = rw;
    e.wa     = wa;
    rdv      = e.err ? 32'h0 : rdat;
    e.wd     = lnk ? {23'b0, pc4} : (m2r ? rdv : alu);
    sb.push_back(e);
    MEM_memread = rd_i; MEM_memwrite = wr_i; MEM_memtoreg = m2r; MEM_regwrite = rw;
    MEM_link = lnk; MEM_wraddr = wa; MEM_pc_4 = pc4; MEM_address = addr;
    MEM_alu_result = alu; MEM_store_data = sd;
    cycles = e.stalls + 1;
    for (int i = 0; i < cycles; i++) begin
      if (e.access) begin
        dmem_ack   = (i == lat);
        dmem_rdata = (i == lat) ? rdat : $urandom;
      end else begin
        dmem_ack   = $urandom_range(0, 1);  // must be ignored with no request
        dmem_rdata = m2r ? rdat : $urandom;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic nop();
    MEM_memread = 0; MEM_memwrite = 0; MEM_memtoreg = 0; MEM_regwrite = 0; MEM_link = 0;
    dmem_ack = 0;
  endtask

  // Monitor: samples on the falling edge, pops one expectation per completion cycle.
  initial begin
    exp_t pend;
    logic pend_v = 1'b0;
    logic prev_stall = 1'b0;
    int   stall_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend_v) begin
          chk("wb_regwrite", 32'(WB_regwrite), 32'(pend.rw));
          chk("wb_wraddr", 32'(WB_wraddr), 32'(pend.wa));
          chk("wb_wdata", WB_wdata, pend.wd);
          pend_v = 1'b0;
        end else if (prev_stall) begin
          chk("wb_bubble", 32'(WB_regwrite), 32'd0);
        end
        prev_stall = 1'b0;
        if (sb.size() > 0) begin
          e = sb[0];
          if (e.access) begin
            chk("dmem_we", 32'(dmem_we), 32'(e.we));
            chk("dmem_addr", 32'(dmem_addr), 32'(e.addr));
            chk("dmem_wdata", dmem_wdata, e.sdata);
          end
          if (mem_stall) begin
            stall_cnt++;
            prev_stall = 1'b1;
            chk("err_in_stall", 32'(mem_err), 32'd0);
            if (stall_cnt > int'(T) + 1) begin
              chk("stall_bound", 32'(stall_cnt), 32'(T));
              void'(sb.pop_front());
              stall_cnt = 0;
            end
          end else begin
            chk("stall_len", 32'(stall_cnt), 32'(e.stalls));
            chk("mem_err", 32'(mem_err), 32'(e.err));
            chk("req_at_end", 32'(dmem_req), 32'(e.access && !e.err));
            pend       = sb.pop_front();
            pend_v     = 1'b1;
            stall_cnt  = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, lat;
    logic rdb, wrb, m2r, lnk;
    nop();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_regwrite", 32'(WB_regwrite), 32'd0);
    chk("rst_wb_wraddr", 32'(WB_wraddr), 32'd0);
    chk("rst_wb_wdata", WB_wdata, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(0, 0, 0, 1, 0, 9'd5, 9'd0, 9'd0, 32'h1234, 32'h0, 32'h0, 0);
    issue(1, 0, 1, 1, 0, 9'd3, 9'd20, 9'h010, 32'h77, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 0, 0, 0, 9'd0, 9'd0, 9'h1FF, 32'h66, 32'hA5A5A5A5, 32'h0, 3);
    issue(1, 0, 1, 1, 0, 9'd9, 9'd0, 9'h033, 32'h99, 32'h0, 32'h1111, 1000);
    issue(0, 0, 1, 1, 1, 9'd31, 9'h0AC, 9'd0, 32'h5, 32'h0, 32'h0, 0);
    issue(1, 0, 1, 1, 0, 9'd4, 9'd0, 9'h044, 32'h0, 32'h0, 32'hCAFEF00D, int'(T));
    issue(1, 1, 0, 1, 0, 9'd6, 9'd0, 9'h055, 32'hABCD, 32'h12, 32'h0, 2);

    for (int n = 0; n < 250; n++) begin
      op  = $urandom_range(0, 4);
      rdb = (op == 1) || (op == 3);
      wrb = (op == 2) || (op == 3);
      lnk = (op == 4);
      m2r = (op == 1 || op == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      lat = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 6));
      issue(rdb, wrb, m2r, 1'($urandom_range(0, 1)), lnk, 9'($urandom), 9'($urandom),
            9'($urandom), $urandom, $urandom, $urandom, lat);
    end

    issue(0, 0, 0, 1, 0, 9'd7, 9'd0, 9'd0, 32'h55, 32'h0, 32'h0, 0);
    nop();
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    sb.delete();

    // Reset in the middle of a waiting load.
    MEM_memread = 1; MEM_memtoreg = 1; MEM_regwrite = 1; MEM_wraddr = 9'd12;
    MEM_address = 9'h0AA; dmem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("wait_req", 32'(dmem_req), 32'd1);
    chk("wait_stall", 32'(mem_stall), 32'd1);
    chk("pre_rst_wraddr", 32'(WB_wraddr), 32'd7);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wb_regwrite", 32'(WB_regwrite), 32'd0);
    chk("mid_rst_wb_wraddr", 32'(WB_wraddr), 32'd0);
    chk("mid_rst_wb_wdata", WB_wdata, 32'd0);
    chk("mid_rst_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1;
    // A cleared counter means the abort lands exactly T cycles after reset release.
    for (int i = 0; i <= int'(T); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk("post_rst_err", 32'(mem_err), 32'(i == int'(T)));
    end
    nop();
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage access controller of the 5-stage MIPS pipeline: the consumer of the EX/MEM boundary register. It turns the registered memory-control bundle (memread/memwrite/memtoreg/regwrite/link) into a req/ack transaction on the data memory, stalls the pipeline while the memory has not acknowledged, and aborts accesses that exceed a timeout. It registers the MEM/WB write-back bundle (register-write enable, destination, selected write data) for the register file.

## Interface
- ACK_TIMEOUT, 15: number of request cycles without ack before abort; legal range 1..255.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- MEM_memread  input  1  load in MEM stage.
- MEM_memwrite  input  1  store in MEM stage.
- MEM_memtoreg  input  1  write-back data comes from memory.
- MEM_regwrite  input  1  instruction writes a register.
- MEM_link  input  1  write-back data is the link address.
- MEM_wraddr  input  9  destination register field.
- MEM_pc_4  input  9  PC+4 of the instruction.
- MEM_address  input  9  data-memory word address.
- MEM_alu_result  input  32  ALU result.
- MEM_store_data  input  32  store data.
- dmem_req  output  1  memory request, held until ack or abort.
- dmem_we  output  1  1 = write, 0 = read; valid while dmem_req.
- dmem_addr  output  9  equals MEM_address.
- dmem_wdata  output  32  equals MEM_store_data.
- dmem_ack  input  1  memory completion; rdata valid in the same cycle.
- dmem_rdata  input  32  read data.
- mem_stall  output  1  holds the PC, IF/ID, ID/EX and EX/MEM.
- mem_err  output  1  one-cycle pulse on timeout abort.
- WB_regwrite  output  1  registered write enable.
- WB_wraddr  output  9  registered destination.
- WB_wdata  output  32  registered write-back data.

## Operation
- access = MEM_memread | MEM_memwrite. If both are high, the operation is a write: dmem_we=1 and no read data is used.
- FSM states are IDLE and WAIT. There is also an 8-bit wait counter, cnt.
- IDLE: dmem_req = access, combinational.
  - If access is high and dmem_ack is high, the access completes in the same cycle. The state stays IDLE.
  - If access is high and dmem_ack is low, go to WAIT with cnt=1.
- WAIT: the inputs are stable because the pipeline is stalled.
  - If dmem_ack is high, complete and go to IDLE with cnt=0.
  - Else if cnt == ACK_TIMEOUT, this is the abort cycle: dmem_req=0, mem_err=1, complete, go to IDLE with cnt=0.
  - Else dmem_req=1 and cnt increments.
- mem_stall = dmem_req & ~dmem_ack. It is 0 in the completion cycle and in the abort cycle.
- dmem_ack while dmem_req=0 is ignored.
- Write-back selection:
  - wdata_sel = MEM_link ? {23'b0, MEM_pc_4} : (MEM_memtoreg ? rd : MEM_alu_result).
  - rd = dmem_rdata on normal completion, or 32'h0 on abort.
- WB register update on every rising edge:
  - When mem_stall=1: WB_regwrite <= 0 (bubble inserted). WB_wraddr and WB_wdata keep their values.
  - Otherwise: WB_regwrite <= MEM_regwrite, WB_wraddr <= MEM_wraddr, WB_wdata <= wdata_sel.
- On abort, WB_regwrite still follows MEM_regwrite, so a load that times out writes 0 to its destination.

## Timing
- Reset values: state=IDLE, cnt=0, WB_regwrite=0, WB_wraddr=0, WB_wdata=0, mem_err=0. dmem_req, dmem_we and mem_stall are 0 once the inputs from the reset EX/MEM register (a NOP) settle.
- Reset asserted mid-access forces IDLE and clears cnt immediately.
- Zero-wait memory (ack in the same cycle): no stall. WB_* are valid one cycle after the instruction enters MEM.
- Ack arriving k cycles after the first request cycle gives k stall cycles. WB_* update on the edge that ends the ack cycle.
- Timeout: dmem_req is high for ACK_TIMEOUT cycles. In the following abort cycle, mem_err=1 and stall=0. Total stall is ACK_TIMEOUT cycles.
- Back-to-back accesses: the next instruction presents its access in the cycle after completion, and its req is asserted immediately. There is no idle gap.
- ack arriving in the same cycle that cnt reaches ACK_TIMEOUT counts as normal completion (ack wins) and mem_err stays 0.

## Test plan
- Reset, then a non-memory instruction (regwrite=1, wraddr=5, alu=0x1234, memtoreg=0): no req, no stall; next cycle WB_regwrite=1, WB_wraddr=5, WB_wdata=0x00001234.
- Load at address 0x010 with zero-wait ack and rdata=0xDEADBEEF: dmem_req=1 and we=0 for 1 cycle, mem_stall=0; next cycle WB_wdata=0xDEADBEEF.
- Store (addr=0x1FF, data=0xA5A5A5A5) with ack after 3 cycles: mem_stall=1 for 3 cycles with WB_regwrite=0 bubbles; dmem_wdata stays 0xA5A5A5A5 throughout; req drops after the ack cycle.
- Load with no ack, ACK_TIMEOUT=4: req high for 4 cycles, then abort cycle with req=0, stall=0, mem_err=1; then WB_wdata=0 with WB_regwrite=1.
- Link instruction (link=1, pc_4=0x0AC, memtoreg=1, no access): WB_wdata=0x000000AC.
- rst_n pulled low while in WAIT with cnt=2: state goes to IDLE immediately, all WB_* become 0, and mem_err does not pulse.
